// File: rtl/fetch_sequencer.sv
// Program-fetch controller for the 16 x 16 instruction ROM: owns the PC, executes
// JMP and HALT locally and hands every other instruction to the decoder via valid/ready.
module fetch_sequencer #(
    parameter int          AW      = 4,
    parameter int          DW      = 16,
    parameter logic [3:0]  JMP_OP  = 4'hE,
    parameter logic [3:0]  HALT_OP = 4'hF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] instr_data,
    output logic [AW-1:0] instr_addr,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          redir_valid,
    input  logic [AW-1:0] redir_addr,
    output logic          halted,
    output logic          busy,
    output logic [7:0]    fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        HALTED
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [AW-1:0] pc;
    logic [AW-1:0] pc_next;
    logic          pc_load;
    logic          capture;
    logic          valid_clr;
    logic          cnt_inc;
    logic          cnt_clr;
    logic          halt_set;
    logic          halt_clr;
    logic [3:0]    opcode;

    assign opcode   = rom_data[DW-1:DW-4];
    assign rom_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Redirect outranks the fetched opcode, so a redirected word is never decoded.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (redir_valid) begin
                    state_next = FETCH;
                end else if (opcode == JMP_OP) begin
                    state_next = FETCH;
                end else if (opcode == HALT_OP) begin
                    state_next = HALTED;
                end else begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (redir_valid || instr_ready) begin
                    state_next = FETCH;
                end
            end
            HALTED: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == FETCH) || (state == HOLD);
        pc_next   = pc;
        pc_load   = 1'b0;
        capture   = 1'b0;
        valid_clr = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        halt_set  = 1'b0;
        halt_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    pc_load = 1'b1;
                    pc_next = start_addr;
                    cnt_clr = 1'b1;
                end
            end
            FETCH: begin
                if (redir_valid) begin
                    pc_load = 1'b1;
                    pc_next = redir_addr;
                end else if (opcode == JMP_OP) begin
                    pc_load = 1'b1;
                    pc_next = rom_data[AW-1:0];
                end else if (opcode == HALT_OP) begin
                    halt_set = 1'b1;
                end else begin
                    capture = 1'b1;
                end
            end
            HOLD: begin
                // A redirect still counts the held instruction if the handshake fired.
                if (redir_valid) begin
                    valid_clr = 1'b1;
                    pc_load   = 1'b1;
                    pc_next   = redir_addr;
                    cnt_inc   = instr_ready;
                end else if (instr_ready) begin
                    valid_clr = 1'b1;
                    pc_load   = 1'b1;
                    pc_next   = pc + AW'(1);
                    cnt_inc   = 1'b1;
                end
            end
            HALTED: begin
                if (start) begin
                    halt_clr = 1'b1;
                    pc_load  = 1'b1;
                    pc_next  = start_addr;
                    cnt_clr  = 1'b1;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            instr_data  <= '0;
            instr_addr  <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_cnt   <= 8'd0;
        end else begin
            if (pc_load) begin
                pc <= pc_next;
            end
            if (capture) begin
                instr_data  <= rom_data;
                instr_addr  <= pc;
                instr_valid <= 1'b1;
            end else if (valid_clr) begin
                instr_valid <= 1'b0;
            end
            if (halt_set) begin
                halted <= 1'b1;
            end else if (halt_clr) begin
                halted <= 1'b0;
            end
            if (cnt_clr) begin
                fetch_cnt <= 8'd0;
            end else if (cnt_inc && (fetch_cnt != 8'hFF)) begin
                fetch_cnt <= fetch_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer: a scoreboard queue holds the expected
// decoder stream, popped by a monitor on every accepted handshake.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  start_addr;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] instr_data;
    logic [3:0]  instr_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic        redir_valid;
    logic [3:0]  redir_addr;
    logic        halted;
    logic        busy;
    logic [7:0]  fetch_cnt;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  addr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] rom [16];
    int          checks = 0;
    int          errors = 0;

    fetch_sequencer #(
        .AW(4),
        .DW(16),
        .JMP_OP(4'hE),
        .HALT_OP(4'hF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .start_addr(start_addr),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .instr_data(instr_data),
        .instr_addr(instr_addr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redir_valid(redir_valid),
        .redir_addr(redir_addr),
        .halted(halted),
        .busy(busy),
        .fetch_cnt(fetch_cnt)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic [3:0] sa, input logic rdy,
                                  input logic rv, input logic [3:0] ra);
        start       = s;
        start_addr  = sa;
        instr_ready = rdy;
        redir_valid = rv;
        redir_addr  = ra;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] d, input logic [3:0] a);
        exp_q.push_back({d, a});
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < 16; i++) rom[i] = w;
    endtask

    task automatic wait_halted(input int max_cycles);
        int n = 0;
        while (!halted && n < max_cycles) begin
            tick(1);
            n++;
        end
        check_output("halt_timeout", {31'd0, halted}, 32'd1);
    endtask

    // Every accepted handshake must match the head of the expected stream.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_instr: got %h@%0d, required none", instr_data, instr_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("instr_data", {16'd0, instr_data}, {16'd0, mon_e.data});
                check_output("instr_addr", {28'd0, instr_addr}, {28'd0, mon_e.addr});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0);
        fill_rom(16'hF000);
        #2;
        check_output("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_output("rst_rom_addr", {28'd0, rom_addr}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_halted", {31'd0, halted}, 32'd0);
        check_output("rst_cnt", {24'd0, fetch_cnt}, 32'd0);
        check_output("rst_data", {16'd0, instr_data}, 32'd0);
        check_output("rst_addr", {28'd0, instr_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        $display("[TB] straight-line fetch");
        rom[0] = 16'h1001; rom[1] = 16'h2002; rom[2] = 16'h3003; rom[3] = 16'hF000;
        push_exp(16'h1001, 0); push_exp(16'h2002, 1); push_exp(16'h3003, 2);
        apply_stimulus(1, 0, 1, 0, 0);
        tick(1);
        apply_stimulus(0, 0, 1, 0, 0);
        check_output("sl_busy", {31'd0, busy}, 32'd1);
        check_output("sl_valid_edge1", {31'd0, instr_valid}, 32'd0);
        for (int e = 2; e <= 8; e++) begin
            tick(1);
            check_output($sformatf("sl_valid_edge%0d", e), {31'd0, instr_valid},
                         ((e % 2 == 0) && (e <= 6)) ? 32'd1 : 32'd0);
        end
        check_output("sl_halted", {31'd0, halted}, 32'd1);
        check_output("sl_busy_halted", {31'd0, busy}, 32'd0);
        check_output("sl_cnt", {24'd0, fetch_cnt}, 32'd3);
        check_output("sl_rom_addr", {28'd0, rom_addr}, 32'd3);

        $display("[TB] back-pressure");
        push_exp(16'h1001, 0); push_exp(16'h2002, 1); push_exp(16'h3003, 2);
        apply_stimulus(1, 0, 0, 0, 0);
        tick(1);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("bp_halted_clr", {31'd0, halted}, 32'd0);
        check_output("bp_cnt_clr", {24'd0, fetch_cnt}, 32'd0);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check_output("bp_valid", {31'd0, instr_valid}, 32'd1);
            check_output("bp_data", {16'd0, instr_data}, 32'h1001);
            check_output("bp_rom_addr", {28'd0, rom_addr}, 32'd0);
            tick(1);
        end
        apply_stimulus(0, 0, 1, 0, 0);
        wait_halted(20);
        check_output("bp_cnt", {24'd0, fetch_cnt}, 32'd3);

        $display("[TB] jump and wrap");
        fill_rom(16'hF000);
        rom[0] = 16'hE00E; rom[14] = 16'h5555; rom[15] = 16'h6666;
        push_exp(16'h5555, 14); push_exp(16'h6666, 15);
        push_exp(16'h5555, 14); push_exp(16'h6666, 15);
        apply_stimulus(1, 14, 1, 0, 0);
        tick(1);
        apply_stimulus(0, 14, 1, 0, 0);
        tick(4);
        check_output("jw_wrap_addr", {28'd0, rom_addr}, 32'd0);
        check_output("jw_wrap_valid", {31'd0, instr_valid}, 32'd0);
        tick(1);
        check_output("jw_jmp_addr", {28'd0, rom_addr}, 32'd14);
        check_output("jw_jmp_valid", {31'd0, instr_valid}, 32'd0);
        tick(1);
        check_output("jw_again_valid", {31'd0, instr_valid}, 32'd1);
        tick(3);
        apply_stimulus(0, 0, 0, 0, 0);
        tick(1);
        check_output("jw_jmp2_addr", {28'd0, rom_addr}, 32'd14);
        tick(1);
        check_output("jw_hold_valid", {31'd0, instr_valid}, 32'd1);
        check_output("jw_hold_addr", {28'd0, instr_addr}, 32'd14);

        $display("[TB] reset while holding");
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rh_valid", {31'd0, instr_valid}, 32'd0);
        check_output("rh_rom_addr", {28'd0, rom_addr}, 32'd0);
        check_output("rh_busy", {31'd0, busy}, 32'd0);
        check_output("rh_cnt", {24'd0, fetch_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 1, 5);
        tick(1);
        check_output("idle_redir_busy", {31'd0, busy}, 32'd0);
        check_output("idle_redir_addr", {28'd0, rom_addr}, 32'd0);

        $display("[TB] self-loop and redirect");
        fill_rom(16'hF000);
        rom[1] = 16'h1111; rom[2] = 16'h2222; rom[3] = 16'hE003; rom[9] = 16'h9999;
        apply_stimulus(1, 3, 0, 0, 0);
        tick(1);
        apply_stimulus(0, 3, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check_output("loop_addr", {28'd0, rom_addr}, 32'd3);
            check_output("loop_busy", {31'd0, busy}, 32'd1);
        end
        apply_stimulus(1, 7, 0, 0, 0);
        tick(1);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("start_busy_ignored", {28'd0, rom_addr}, 32'd3);
        push_exp(16'h1111, 1);
        apply_stimulus(0, 0, 1, 1, 1);
        tick(1);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("rf_addr", {28'd0, rom_addr}, 32'd1);
        check_output("rf_valid", {31'd0, instr_valid}, 32'd0);
        tick(1);
        check_output("rf_hold_valid", {31'd0, instr_valid}, 32'd1);
        apply_stimulus(0, 0, 1, 1, 9);
        tick(1);
        apply_stimulus(0, 0, 1, 0, 0);
        check_output("rh_drop_valid", {31'd0, instr_valid}, 32'd0);
        check_output("rh_target", {28'd0, rom_addr}, 32'd9);
        check_output("rh_cnt_inc", {24'd0, fetch_cnt}, 32'd1);
        push_exp(16'h9999, 9);
        tick(1);
        check_output("rh_next_valid", {31'd0, instr_valid}, 32'd1);
        wait_halted(10);
        check_output("rh_final_cnt", {24'd0, fetch_cnt}, 32'd2);
        check_output("rh_halt_addr", {28'd0, rom_addr}, 32'd10);

        $display("[TB] restart from halted");
        push_exp(16'h2222, 2);
        apply_stimulus(1, 2, 0, 0, 0);
        tick(1);
        apply_stimulus(0, 2, 0, 0, 0);
        check_output("rs_halted", {31'd0, halted}, 32'd0);
        check_output("rs_cnt", {24'd0, fetch_cnt}, 32'd0);
        check_output("rs_valid_early", {31'd0, instr_valid}, 32'd0);
        tick(1);
        check_output("rs_valid", {31'd0, instr_valid}, 32'd1);
        check_output("rs_instr_addr", {28'd0, instr_addr}, 32'd2);
        apply_stimulus(0, 2, 1, 0, 0);
        tick(1);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("rs_next_addr", {28'd0, rom_addr}, 32'd3);
        check_output("rs_cnt_after", {24'd0, fetch_cnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("rs_reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] counter saturation");
        for (int i = 0; i < 16; i++) rom[i] = 16'h0A00 | 16'(i);
        for (int k = 0; k < 260; k++) push_exp(16'h0A00 | 16'(k % 16), 4'(k % 16));
        tick(1);
        apply_stimulus(1, 0, 1, 0, 0);
        tick(1);
        apply_stimulus(0, 0, 1, 0, 0);
        tick(508);
        check_output("sat_254", {24'd0, fetch_cnt}, 32'd254);
        tick(2);
        check_output("sat_255", {24'd0, fetch_cnt}, 32'd255);
        tick(10);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("sat_hold", {24'd0, fetch_cnt}, 32'd255);
        tick(2);
        rst_n = 1'b0;
        #1;

        check_output("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
